// File: rtl/truth_table_scanner_pkg.sv
// truth_table_scanner_pkg: shared state encoding for the truth-table scanner
package truth_table_scanner_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_EMIT, S_DONE} state_t;
endpackage

// File: rtl/tt_upper_bits_zero.sv
// tt_upper_bits_zero: flags that no table bit above ptr is set
module tt_upper_bits_zero #(
  parameter int N_VARS = 4,
  localparam int T = 1 << N_VARS
) (
  input  logic [T-1:0]    table_bits,
  input  logic [N_VARS:0] ptr,
  output logic            none_above
);
  assign none_above = ~|(table_bits >> (ptr + 1'b1));
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps an external function, builds SoP/PoS tables, streams minterms
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_VARS = 4,
  localparam int T = 1 << N_VARS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_VARS-1:0] vars_out,
  input  logic              f_sop,
  input  logic              f_pos,
  output logic [T-1:0]      table_sop,
  output logic [T-1:0]      table_pos,
  output logic [T-1:0]      mismatch_mask,
  output logic              mismatch,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_VARS-1:0] m_index,
  output logic              m_last
);
  localparam logic [N_VARS:0] LAST = (N_VARS + 1)'(T - 1);
  state_t state, nxt;
  logic [N_VARS:0] idx, ptr;
  logic [N_VARS-1:0] ptr_lo;
  logic advance, none_above;
  assign ptr_lo = ptr[N_VARS-1:0];
  assign advance = ~table_sop[ptr_lo] | m_ready;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign m_valid = (state == S_EMIT) & table_sop[ptr_lo];
  assign m_index = ptr_lo;
  assign m_last = m_valid & none_above;
  assign mismatch_mask = table_sop ^ table_pos;
  assign mismatch = |mismatch_mask;
  tt_upper_bits_zero #(.N_VARS(N_VARS)) u_upper (
    .table_bits(table_sop),
    .ptr(ptr),
    .none_above(none_above)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = start ? S_DRIVE : S_IDLE;
      S_DRIVE:  nxt = S_SAMPLE;
      S_SAMPLE: nxt = (idx == LAST) ? S_EMIT : S_DRIVE;
      S_EMIT:   nxt = (advance && ptr == LAST) ? S_DONE : S_EMIT;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx <= '0;
      ptr <= '0;
      vars_out <= '0;
      table_sop <= '0;
      table_pos <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: if (start) begin
          table_sop <= '0;
          table_pos <= '0;
          idx <= '0;
        end
        S_DRIVE: vars_out <= idx[N_VARS-1:0];
        S_SAMPLE: begin
          table_sop[idx[N_VARS-1:0]] <= f_sop;
          table_pos[idx[N_VARS-1:0]] <= f_pos;
          idx <= idx + 1'b1;
          if (idx == LAST) ptr <= '0;
        end
        S_EMIT: if (advance) ptr <= ptr + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: directed checks of sweep, tables, minterm stream and timing
module tb_truth_table_scanner;
  logic clk = 0, reset = 1, start = 0, m_ready = 1;
  logic f_sop, f_pos, busy, done, mismatch, m_valid, m_last;
  logic [3:0] vars_out, m_index;
  logic [15:0] table_sop, table_pos, mismatch_mask;
  logic [15:0] ref_sop = '0, ref_pos = '0;
  int total = 0, passed = 0;

  always #5 clk = ~clk;
  assign f_sop = ref_sop[vars_out];
  assign f_pos = ref_pos[vars_out];

  truth_table_scanner #(.N_VARS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .vars_out(vars_out), .f_sop(f_sop), .f_pos(f_pos),
    .table_sop(table_sop), .table_pos(table_pos),
    .mismatch_mask(mismatch_mask), .mismatch(mismatch),
    .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_last(m_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic scan(input string name, input logic [15:0] sop, input logic [15:0] pos,
                      input logic [15:0] exp_mask, input int stall_at, input bit poke,
                      input int exp_done, input int exp_cnt, input int exp_last);
    int n, done_at, dones, cnt, last_idx, lasts, stall, prev;
    logic [15:0] got;
    bit order_ok;
    n = 0; done_at = -1; dones = 0; cnt = 0; last_idx = -1; lasts = 0;
    stall = 0; prev = -1; got = '0; order_ok = 1;
    ref_sop = sop;
    ref_pos = pos;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    while (n < 200 && !(done_at >= 0 && n >= done_at + 3)) begin
      @(negedge clk);
      n++;
      if (n == 1) check({name, " busy_after_start"}, 32'(busy), 32'd1);
      if (done) begin
        dones++;
        if (done_at < 0) done_at = n;
      end
      start = poke && (n == 10 || done);
      if (m_last) begin
        lasts++;
        last_idx = m_valid ? int'(m_index) : -2;
      end
      m_ready = 1;
      if (m_valid && int'(m_index) == stall_at && stall < 5) begin
        m_ready = 0;
        stall++;
      end
      if (m_valid && m_ready) begin
        got[m_index] = 1'b1;
        cnt++;
        if (int'(m_index) <= prev) order_ok = 0;
        prev = int'(m_index);
      end
    end
    m_ready = 1;
    start = 0;
    check({name, " table_sop"}, 32'(table_sop), 32'(sop));
    check({name, " table_pos"}, 32'(table_pos), 32'(pos));
    check({name, " mismatch_mask"}, 32'(mismatch_mask), 32'(exp_mask));
    check({name, " mismatch"}, 32'(mismatch), 32'(exp_mask != 0));
    check({name, " stream_set"}, 32'(got), 32'(sop));
    check({name, " stream_count"}, cnt, exp_cnt);
    check({name, " stream_order"}, 32'(order_ok), 32'd1);
    check({name, " last_count"}, lasts, (exp_cnt != 0) ? 1 : 0);
    check({name, " last_index"}, last_idx, exp_last);
    check({name, " done_cycle"}, done_at, exp_done);
    check({name, " done_pulses"}, dones, 1);
    check({name, " stall_cycles"}, stall, (stall_at >= 0) ? 5 : 0);
    check({name, " idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, dones;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset vars_out", 32'(vars_out), 32'd0);
    check("reset table_sop", 32'(table_sop), 32'd0);
    check("reset m_valid", 32'(m_valid), 32'd0);

    scan("t1", 16'hE5AB, 16'hE5AB, 16'h0000, -1, 0, 49, 10, 15);
    scan("t2", 16'hE5AB, 16'hE7AB, 16'h0200, -1, 0, 49, 10, 15);
    scan("t3", 16'h0000, 16'h0000, 16'h0000, -1, 0, 49, 0, -1);
    scan("t4", 16'hE5AB, 16'hE5AB, 16'h0000, 3, 0, 54, 10, 15);

    ref_sop = 16'hE5AB;
    ref_pos = 16'hE7AB;
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    n = 0;
    while (n < 100 && vars_out != 4'd6) begin
      @(negedge clk);
      n++;
    end
    check("t5 reached vars6", 32'(vars_out), 32'd6);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("t5 busy", 32'(busy), 32'd0);
    check("t5 vars_out", 32'(vars_out), 32'd0);
    check("t5 table_sop", 32'(table_sop), 32'd0);
    check("t5 table_pos", 32'(table_pos), 32'd0);
    check("t5 mismatch_mask", 32'(mismatch_mask), 32'd0);
    check("t5 outputs", {27'd0, done, mismatch, m_valid, m_last, 1'b0} | 32'(m_index), 32'd0);
    dones = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || m_valid || busy) dones++;
    end
    check("t5 quiet_after_reset", dones, 0);
    scan("t5r", 16'hE5AB, 16'hE5AB, 16'h0000, -1, 0, 49, 10, 15);

    scan("t6", 16'hE5AB, 16'hE5AB, 16'h0000, -1, 1, 49, 10, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
